// File: rtl/force_iteration_sequencer.sv
// force_iteration_sequencer: drives iter_start / motion_update_start for the force loop,
// tracks ref-writeback completion, ring drain window, iteration count and a stall watchdog.
`default_nettype none

module force_iteration_sequencer #(
  parameter int NUM_CELLS     = 64,
  parameter int DRAIN_CYCLES  = NUM_CELLS,
  parameter int NUM_ITER      = 16,
  parameter int ITER_WIDTH    = $clog2(NUM_ITER + 1),
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_CELLS-1:0]  ref_wb_issued,
  input  logic                  goto_next_ref,
  input  logic                  all_reading_done,
  input  logic                  all_filter_buffer_empty,
  input  logic [NUM_CELLS-1:0]  force_wr_enable,
  input  logic                  force_cache_input_buffer_empty,
  input  logic                  mu_done,
  output logic                  iter_start,
  output logic                  all_ref_wb_issued,
  output logic                  interconnect_empty,
  output logic                  all_force_wr_issued,
  output logic                  motion_update_start,
  output logic [ITER_WIDTH-1:0] iter_count,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 2);
  localparam logic [DRAIN_W-1:0]    DRAIN_MAX = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [ITER_WIDTH-1:0] LAST_ITER = ITER_WIDTH'(NUM_ITER - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORCE   = 2'd1,
    MU_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                   state;
  logic [NUM_CELLS-1:0]     cap;
  logic [DRAIN_W-1:0]       drain_cnt;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;

  logic start_go;
  logic force_go;
  logic mu_go;
  logic activity;

  assign busy               = (state == FORCE) || (state == MU_WAIT);
  assign interconnect_empty = all_ref_wb_issued && (drain_cnt == DRAIN_MAX);
  assign all_force_wr_issued = (force_wr_enable == '0) && force_cache_input_buffer_empty &&
                               all_filter_buffer_empty && interconnect_empty;

  assign start_go = ((state == IDLE) || (state == DONE)) && start;
  assign force_go = (state == FORCE) && all_reading_done && all_force_wr_issued;
  assign mu_go    = (state == MU_WAIT) && mu_done;
  // Any state transition or loop traffic counts as progress for the watchdog.
  assign activity = start_go || force_go || mu_go || (|ref_wb_issued) || goto_next_ref || mu_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cap                 <= '0;
      drain_cnt           <= '0;
      wd_cnt              <= '0;
      all_ref_wb_issued   <= 1'b0;
      iter_start          <= 1'b0;
      motion_update_start <= 1'b0;
      iter_count          <= '0;
      done                <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      iter_start          <= 1'b0;
      motion_update_start <= 1'b0;

      if (activity || !busy) begin
        wd_cnt <= '0;
      end else if (wd_cnt != '1) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_cnt == '1) begin
        timeout <= 1'b1;
      end

      if (state == FORCE && !force_go) begin
        // A set in the same cycle as goto_next_ref survives the clear.
        cap <= (goto_next_ref ? '0 : cap) | ref_wb_issued;
        if (goto_next_ref) begin
          all_ref_wb_issued <= 1'b0;
          drain_cnt         <= '0;
        end else if ((&cap) && !all_ref_wb_issued) begin
          all_ref_wb_issued <= 1'b1;
          drain_cnt         <= '0;
        end else if (all_ref_wb_issued && drain_cnt != DRAIN_MAX) begin
          drain_cnt <= drain_cnt + 1'b1;
        end
      end else begin
        cap               <= '0;
        all_ref_wb_issued <= 1'b0;
        drain_cnt         <= '0;
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            iter_count <= '0;
            done       <= 1'b0;
            iter_start <= 1'b1;
            state      <= FORCE;
          end
        end
        FORCE: begin
          if (force_go) begin
            motion_update_start <= 1'b1;
            state               <= MU_WAIT;
          end
        end
        MU_WAIT: begin
          if (mu_done) begin
            iter_count <= iter_count + 1'b1;
            if (iter_count == LAST_ITER) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              iter_start <= 1'b1;
              state      <= FORCE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_force_iteration_sequencer.sv
// Directed bench for force_iteration_sequencer (4 cells, drain 4, 2 iterations, 4-bit watchdog).
`default_nettype none

module tb_force_iteration_sequencer;

  localparam int NC = 4;
  localparam int IW = $clog2(2 + 1);

  logic          clk = 1'b0;
  logic          rst, start, goto_next_ref, all_reading_done, all_filter_buffer_empty;
  logic          force_cache_input_buffer_empty, mu_done;
  logic [NC-1:0] ref_wb_issued, force_wr_enable;
  logic          iter_start, all_ref_wb_issued, interconnect_empty, all_force_wr_issued;
  logic          motion_update_start, busy, done, timeout;
  logic [IW-1:0] iter_count;

  int checks = 0;
  int errors = 0;

  force_iteration_sequencer #(
    .NUM_CELLS(NC), .DRAIN_CYCLES(4), .NUM_ITER(2), .TIMEOUT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ref_wb_issued(ref_wb_issued),
    .goto_next_ref(goto_next_ref), .all_reading_done(all_reading_done),
    .all_filter_buffer_empty(all_filter_buffer_empty), .force_wr_enable(force_wr_enable),
    .force_cache_input_buffer_empty(force_cache_input_buffer_empty), .mu_done(mu_done),
    .iter_start(iter_start), .all_ref_wb_issued(all_ref_wb_issued),
    .interconnect_empty(interconnect_empty), .all_force_wr_issued(all_force_wr_issued),
    .motion_update_start(motion_update_start), .iter_count(iter_count),
    .busy(busy), .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; goto_next_ref = 1'b0; mu_done = 1'b0;
    ref_wb_issued = '0; force_wr_enable = '0;
    all_reading_done = 1'b1; all_filter_buffer_empty = 1'b1; force_cache_input_buffer_empty = 1'b1;
    repeat (2) tick();
    chk("rst_iter_start", iter_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_all_ref", all_ref_wb_issued, 0);
    chk("rst_ic_empty", interconnect_empty, 0);
    chk("rst_mus", motion_update_start, 0);
    rst = 1'b0;
    tick();

    mu_done = 1'b1; tick(); mu_done = 1'b0;
    chk("idle_mu_done_count", iter_count, 0);
    chk("idle_mu_done_busy", busy, 0);

    // Basic run, first iteration
    start = 1'b1; tick(); start = 1'b0;
    chk("start_iter_start", iter_start, 1);
    chk("start_busy", busy, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_in_force_ignored", iter_start, 0);
    ref_wb_issued = 4'hF; tick(); ref_wb_issued = '0;
    chk("all_ref_not_yet", all_ref_wb_issued, 0);
    tick();
    chk("all_ref_rise", all_ref_wb_issued, 1);
    chk("ic_empty_at_flag", interconnect_empty, 0);
    repeat (3) tick();
    chk("ic_empty_early", interconnect_empty, 0);
    chk("mus_early", motion_update_start, 0);
    tick();
    chk("ic_empty_rise", interconnect_empty, 1);
    chk("afwi_quiet", all_force_wr_issued, 1);
    chk("mus_not_same_cycle", motion_update_start, 0);
    tick();
    chk("mus_pulse", motion_update_start, 1);
    chk("mus_ic_cleared", interconnect_empty, 0);
    tick();
    chk("mus_one_cycle", motion_update_start, 0);
    mu_done = 1'b1; tick(); mu_done = 1'b0;
    chk("iter1_count", iter_count, 1);
    chk("iter1_iter_start", iter_start, 1);
    chk("iter1_done", done, 0);

    // Second iteration with force_wr_enable blocking quiescence
    ref_wb_issued = 4'hF; tick(); ref_wb_issued = '0;
    force_wr_enable = 4'b0010;
    tick();
    repeat (4) tick();
    chk("blk_wr_ic_empty", interconnect_empty, 1);
    chk("blk_wr_afwi", all_force_wr_issued, 0);
    repeat (3) tick();
    chk("blk_wr_no_mus", motion_update_start, 0);
    force_wr_enable = '0; #1;
    chk("blk_wr_release_afwi", all_force_wr_issued, 1);
    tick();
    chk("blk_wr_mus", motion_update_start, 1);
    tick();
    mu_done = 1'b1; tick(); mu_done = 1'b0;
    chk("run_done", done, 1);
    chk("run_iter_count", iter_count, 2);
    chk("run_busy", busy, 0);
    chk("run_no_iter_start", iter_start, 0);

    // Second run: staggered capture, collision, cache-buffer block
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun_done_clear", done, 0);
    chk("rerun_count_clear", iter_count, 0);
    chk("rerun_iter_start", iter_start, 1);
    ref_wb_issued = 4'b0001; tick(); ref_wb_issued = '0;
    repeat (3) tick();
    ref_wb_issued = 4'b0110; tick(); ref_wb_issued = '0;
    repeat (10) tick();
    chk("stagger_partial", all_ref_wb_issued, 0);
    ref_wb_issued = 4'b1000; tick(); ref_wb_issued = '0;
    chk("stagger_one_after", all_ref_wb_issued, 0);
    tick();
    chk("stagger_rise", all_ref_wb_issued, 1);

    goto_next_ref = 1'b1; tick(); goto_next_ref = 1'b0;
    chk("goto_clears_flag", all_ref_wb_issued, 0);
    ref_wb_issued = 4'b0011; tick();
    goto_next_ref = 1'b1; ref_wb_issued = 4'b0100; tick();
    goto_next_ref = 1'b0; ref_wb_issued = '0;
    chk("collision_cap", dut.cap, 4'b0100);
    chk("collision_flag", all_ref_wb_issued, 0);
    ref_wb_issued = 4'b1011; tick(); ref_wb_issued = '0;
    tick();
    chk("collision_flag_rise", all_ref_wb_issued, 1);

    force_cache_input_buffer_empty = 1'b0;
    repeat (5) tick();
    chk("blk_fc_ic_empty", interconnect_empty, 1);
    chk("blk_fc_afwi", all_force_wr_issued, 0);
    chk("blk_fc_no_mus", motion_update_start, 0);
    force_cache_input_buffer_empty = 1'b1; #1;
    chk("blk_fc_release_afwi", all_force_wr_issued, 1);
    tick();
    chk("blk_fc_mus", motion_update_start, 1);

    mu_done = 1'b1; tick(); mu_done = 1'b0;
    chk("run2_iter1_count", iter_count, 1);
    chk("run2_iter1_start", iter_start, 1);
    ref_wb_issued = 4'hF; tick(); ref_wb_issued = '0;
    repeat (6) tick();
    chk("run2_mus_latency", motion_update_start, 1);

    // Reset while in MU_WAIT
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", iter_count, 0);
    chk("midrst_iter_start", iter_start, 0);
    mu_done = 1'b1; tick(); mu_done = 1'b0;
    chk("midrst_mu_ignored_count", iter_count, 0);
    chk("midrst_mu_ignored_start", iter_start, 0);
    chk("midrst_mu_ignored_done", done, 0);

    // Watchdog
    start = 1'b1; tick(); start = 1'b0;
    repeat (14) tick();
    chk("wd_not_yet", timeout, 0);
    repeat (3) tick();
    chk("wd_timeout", timeout, 1);
    chk("wd_state_kept", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("wd_rst_timeout", timeout, 0);
    chk("wd_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/force_iteration_sequencer.md
# force_iteration_sequencer

Top-level sequencer for the range-limited force/motion-update loop. It captures per-PE reference-writeback completion and waits a fixed drain window for ring packets to land. It then qualifies the global "all forces written" condition, fires motion update, and counts iterations up to a programmed limit. A stall watchdog flags a hung loop. It sits beside the broadcast controller and drives its `iter_start`, plus the motion-update controller's start.

## Interface
- `NUM_CELLS`, 64, number of PEs / force caches
- `DRAIN_CYCLES`, NUM_CELLS, cycles to wait after last ref writeback for ring to empty
- `NUM_ITER`, 16, iterations per run (>=1)
- `ITER_WIDTH`, $clog2(NUM_ITER+1), iteration counter width
- `TIMEOUT_WIDTH`, 16, watchdog counter width; timeout at all-ones

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  run request pulse
- `ref_wb_issued`  in  NUM_CELLS  per-PE pulse: ref particle force writeback issued
- `goto_next_ref`  in  1  broadcast controller advancing to next ref particle
- `all_reading_done`  in  1  all PEs finished reading
- `all_filter_buffer_empty`  in  1  all filter buffers empty
- `force_wr_enable`  in  NUM_CELLS  ring output valids to force caches
- `force_cache_input_buffer_empty`  in  1  all force cache input buffers empty
- `mu_done`  in  1  motion update complete pulse
- `iter_start`  out  1  one-cycle pulse: begin force phase
- `all_ref_wb_issued`  out  1  every PE has issued its ref writeback
- `interconnect_empty`  out  1  drain window elapsed
- `all_force_wr_issued`  out  1  combinational force-phase quiescence
- `motion_update_start`  out  1  one-cycle pulse
- `iter_count`  out  ITER_WIDTH  completed iterations
- `busy`  out  1  state != IDLE/DONE
- `done`  out  1  run finished
- `timeout`  out  1  sticky watchdog flag

## Operation
- States: IDLE, FORCE, MU_WAIT, DONE. Reset -> IDLE; all outputs 0, capture vector 0, counters 0.
- IDLE/DONE + `start`: iter_count<=0, done<=0, iter_start pulses, -> FORCE. `start` ignored in FORCE/MU_WAIT.
- Capture (FORCE only): `cap[k]` sets on `ref_wb_issued[k]`. When `cap` is all ones, all_ref_wb_issued<=1 and drain_cnt<=0.
- Drain: while all_ref_wb_issued=1, drain_cnt increments and saturates at DRAIN_CYCLES.
- interconnect_empty = all_ref_wb_issued & (drain_cnt==DRAIN_CYCLES).
- `goto_next_ref` clears cap, all_ref_wb_issued and drain_cnt. A `ref_wb_issued[k]` in the same cycle still sets `cap[k]`: set wins over clear per bit.
- all_force_wr_issued = (force_wr_enable==0) & force_cache_input_buffer_empty & all_filter_buffer_empty & interconnect_empty.
- FORCE, all_reading_done & all_force_wr_issued: motion_update_start pulses, cap/flag/drain_cnt clear, -> MU_WAIT.
- MU_WAIT + `mu_done`: iter_count++.
  - If the new count == NUM_ITER: -> DONE, done<=1 (held).
  - Otherwise: iter_start pulses, -> FORCE.
- `mu_done` outside MU_WAIT is ignored.
- Watchdog: wd_cnt clears on any state change, any `ref_wb_issued` bit, `goto_next_ref` or `mu_done`. Otherwise it increments in FORCE/MU_WAIT.
  - At all-ones: timeout<=1 (sticky until rst). State is not altered.
- `rst` mid-run returns to IDLE in one cycle and discards all progress.

## Timing
- iter_start: registered, high exactly one cycle, in the cycle after `start` sampled (or after `mu_done` sampled).
- all_ref_wb_issued: rises one cycle after the cycle in which cap becomes all ones, i.e. 2 cycles after the final `ref_wb_issued` pulse.
- interconnect_empty: rises DRAIN_CYCLES cycles after all_ref_wb_issued.
- motion_update_start: registered, one cycle after the qualifying condition is sampled. It never pulses twice per iteration.
- done/iter_count: update in the cycle after `mu_done`.
- busy: decoded from the state register.

## Test plan
- Basic run, NUM_CELLS=4, DRAIN_CYCLES=4, NUM_ITER=2:
  - Start, pulse all ref_wb_issued at cycle 10, hold buffers empty, all_reading_done=1.
  - all_ref_wb_issued rises at cycle 12, interconnect_empty at cycle 16, motion_update_start at cycle 17.
  - mu_done -> iter_count=1 plus iter_start; second mu_done -> done=1, iter_count=2.
- Staggered capture: ref_wb_issued bits on cycles 5, 9, 9, 20 -> all_ref_wb_issued rises at cycle 22, not earlier.
- Set/clear collision: goto_next_ref and ref_wb_issued[2] in the same cycle -> cap=4'b0100 the next cycle.
- Blocked quiescence: any force_wr_enable bit high, or force_cache_input_buffer_empty=0, after the drain elapses -> no motion_update_start until released. The pulse comes 1 cycle after release.
- Watchdog with TIMEOUT_WIDTH=4: no activity in FORCE -> timeout=1 after 15 cycles, state stays FORCE. rst clears timeout and returns to IDLE.
- Reset mid-MU_WAIT: rst -> next cycle busy=0, iter_count=0, no iter_start. A later mu_done is ignored.
